// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package timer_pkg;

    // Word offsets decoded from Addr[3:2]
    localparam logic [1:0] ADDR_CTRL   = 2'b00;
    localparam logic [1:0] ADDR_PRESET = 2'b01;
    localparam logic [1:0] ADDR_COUNT  = 2'b10;

    // CTRL register bit positions
    localparam int EN_BIT   = 0;
    localparam int MODE_LSB = 1;
    localparam int MODE_MSB = 2;
    localparam int IM_BIT   = 3;

    // Only 2'b01 selects periodic; every other MODE value behaves as one-shot
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_counter.sv
// Countdown timer with CTRL/PRESET/COUNT registers and a maskable expiry interrupt (one-shot level or periodic pulse).
// Latency: writes visible on reads from the write edge; IRQ rises PRESET+3 edges after the edge that sets EN.
// Backpressure: none; the bus bridge may access every cycle, reads are combinational.
//
// Ports:
//   clk    - single clock, rising edge
//   reset  - synchronous, active-low
//   Addr   - word address [31:2]; only [3:2] decoded
//   WE     - device-qualified write enable
//   Din    - write data
//   Dout   - combinational read data for Addr
//   IRQ    - interrupt request (CTRL.IM & pending)
module timer_counter
    import timer_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int CTRL_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:2]  Addr,
    input  logic         WE,
    input  logic [31:0]  Din,
    output logic [31:0]  Dout,
    output logic         IRQ
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CTRL_W-1:0] ctrl,    ctrl_nxt;
    logic [CNT_W-1:0]  preset,  preset_nxt;
    logic [CNT_W-1:0]  count,   count_nxt;
    logic              pending, pending_nxt;
    state_t            state,   state_nxt;

    logic              wr_ctrl;
    logic              wr_preset;
    logic              en;
    logic              periodic;
    logic              pend_set;
    logic              pend_clr;
    logic              en_clr;

    // Upper address bits are decoded by the bridge, not here
    logic              unused_addr;
    assign unused_addr = ^Addr[31:4];

    assign wr_ctrl   = WE && (Addr[3:2] == ADDR_CTRL);
    assign wr_preset = WE && (Addr[3:2] == ADDR_PRESET);
    assign en        = ctrl[EN_BIT];
    assign periodic  = (ctrl[MODE_MSB:MODE_LSB] == MODE_PERIODIC);

    // FSM next state and counter update, driven by the CTRL value held before this edge
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        en_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_nxt = LOAD;
            end
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (count == '0) begin
                    state_nxt = INT;
                    pend_set  = 1'b1;
                end else begin
                    count_nxt = count - CNT_ONE;
                end
            end
            INT: begin
                if (periodic) begin
                    state_nxt = LOAD;
                    pend_clr  = 1'b1;
                end else begin
                    en_clr    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register file: a software CTRL write overrides the FSM's EN clear
    // and its pending set/clear in the same cycle.
    always_comb begin
        ctrl_nxt    = ctrl;
        preset_nxt  = preset;
        pending_nxt = pending;

        if (wr_ctrl) begin
            ctrl_nxt = Din[CTRL_W-1:0];
        end else if (en_clr) begin
            ctrl_nxt         = ctrl;
            ctrl_nxt[EN_BIT] = 1'b0;
        end

        if (wr_preset) preset_nxt = Din[CNT_W-1:0];

        if (wr_ctrl)       pending_nxt = 1'b0;
        else if (pend_set) pending_nxt = 1'b1;
        else if (pend_clr) pending_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
            state   <= IDLE;
        end else begin
            ctrl    <= ctrl_nxt;
            preset  <= preset_nxt;
            count   <= count_nxt;
            pending <= pending_nxt;
            state   <= state_nxt;
        end
    end

    // Read mux; narrower registers are zero-extended, offset 11 reads 0
    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            ADDR_CTRL:   Dout[CTRL_W-1:0] = ctrl;
            ADDR_PRESET: Dout[CNT_W-1:0]  = preset;
            ADDR_COUNT:  Dout[CNT_W-1:0]  = count;
            default:     Dout = '0;
        endcase
    end

    assign IRQ = ctrl[IM_BIT] & pending;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: table-driven one-shot run plus hand sequences for corner cases.
// Latency: n/a.
// Backpressure: n/a.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_cmp = 0;
    int n_bad = 0;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic        we;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bus cycle, let it take effect at the next edge, leave Addr in place
    task automatic apply(input logic [1:0] a, input logic we_i, input logic [31:0] d);
        Addr = {28'h0, a};
        WE   = we_i;
        Din  = d;
        tick();
        WE   = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        Addr = {28'h0, a};
        WE   = 1'b0;
        #1;
        chk(name, Dout, exp);
    endtask

    // Reset held for two edges while a CTRL write is attempted
    task automatic do_reset();
        reset = 1'b0;
        Addr  = '0;
        WE    = 1'b1;
        Din   = 32'hF;
        tick();
        tick();
        reset = 1'b1;
        WE    = 1'b0;
        Din   = '0;
    endtask

    initial begin
        reset = 1'b0;
        Addr  = '0;
        WE    = 1'b0;
        Din   = '0;

        // PRESET=3, CTRL=EN|IM at edge E (row 1), then watch the count and IRQ
        vecs[0]  = '{2'd1, 1'b1, 32'd3,   32'd3, 1'b0};
        vecs[1]  = '{2'd0, 1'b1, 32'h9,   32'h9, 1'b0};
        vecs[2]  = '{2'd2, 1'b0, 32'd0,   32'd0, 1'b0};  // E+1 LOAD
        vecs[3]  = '{2'd2, 1'b0, 32'd0,   32'd3, 1'b0};  // E+2
        vecs[4]  = '{2'd2, 1'b0, 32'd0,   32'd2, 1'b0};
        vecs[5]  = '{2'd2, 1'b0, 32'd0,   32'd1, 1'b0};
        vecs[6]  = '{2'd2, 1'b0, 32'd0,   32'd0, 1'b0};  // E+5
        vecs[7]  = '{2'd2, 1'b0, 32'd0,   32'd0, 1'b1};  // E+6 IRQ rises
        vecs[8]  = '{2'd0, 1'b0, 32'd0,   32'h8, 1'b1};  // EN auto-cleared
        vecs[9]  = '{2'd0, 1'b0, 32'd0,   32'h8, 1'b1};  // level holds
        vecs[10] = '{2'd0, 1'b1, 32'd0,   32'h0, 1'b0};  // CTRL write drops IRQ
        vecs[11] = '{2'd0, 1'b0, 32'd0,   32'h0, 1'b0};

        // Reset
        do_reset();
        rd_chk("reset ctrl",   2'd0, 32'h0);
        rd_chk("reset preset", 2'd1, 32'h0);
        rd_chk("reset count",  2'd2, 32'h0);
        chk("reset irq", {31'h0, IRQ}, 32'h0);

        // One-shot table
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].addr, vecs[i].we, vecs[i].din);
            chk($sformatf("oneshot[%0d] dout", i), Dout, vecs[i].exp_dout);
            chk($sformatf("oneshot[%0d] irq", i), {31'h0, IRQ}, {31'h0, vecs[i].exp_irq});
        end

        // Periodic: PRESET=2 -> one-cycle pulse at E+5, E+10, E+15
        do_reset();
        apply(2'd1, 1'b1, 32'd2);
        apply(2'd0, 1'b1, 32'hB);
        for (int k = 1; k <= 16; k++) begin
            apply(2'd2, 1'b0, 32'd0);
            chk($sformatf("periodic irq E+%0d", k), {31'h0, IRQ}, {31'h0, (k % 5) == 0});
        end
        apply(2'd0, 1'b1, 32'h0);
        chk("periodic stop irq", {31'h0, IRQ}, 32'h0);

        // Masked one-shot: no IRQ, FSM still clears EN; setting IM afterwards stays quiet
        do_reset();
        apply(2'd1, 1'b1, 32'd1);
        apply(2'd0, 1'b1, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            apply(2'd0, 1'b0, 32'd0);
            chk($sformatf("masked irq E+%0d", k), {31'h0, IRQ}, 32'h0);
        end
        rd_chk("masked ctrl en cleared", 2'd0, 32'h0);
        rd_chk("masked count",           2'd2, 32'h0);
        apply(2'd0, 1'b1, 32'h8);
        chk("masked im write dout", Dout, 32'h8);
        chk("masked im write irq", {31'h0, IRQ}, 32'h0);
        tick();
        tick();
        chk("masked im later irq", {31'h0, IRQ}, 32'h0);

        // PRESET=0 with MODE=2'b10 (behaves as one-shot): IRQ at E+3
        do_reset();
        apply(2'd0, 1'b1, 32'hD);
        for (int k = 1; k <= 3; k++) begin
            apply(2'd2, 1'b0, 32'd0);
            chk($sformatf("preset0 irq E+%0d", k), {31'h0, IRQ}, {31'h0, k == 3});
        end
        tick();
        tick();
        rd_chk("preset0 ctrl after", 2'd0, 32'hC);
        chk("preset0 irq held", {31'h0, IRQ}, 32'h1);

        // Pause at COUNT=6, hold, then full restart from PRESET
        do_reset();
        apply(2'd1, 1'b1, 32'd10);
        apply(2'd0, 1'b1, 32'h9);
        for (int k = 1; k <= 5; k++) apply(2'd2, 1'b0, 32'd0);
        chk("pause count E+5", Dout, 32'd7);
        apply(2'd0, 1'b1, 32'h8);
        rd_chk("pause count at clear", 2'd2, 32'd6);
        for (int k = 1; k <= 5; k++) begin
            apply(2'd2, 1'b0, 32'd0);
            chk($sformatf("pause hold %0d", k), Dout, 32'd6);
        end
        apply(2'd0, 1'b1, 32'h9);
        for (int k = 1; k <= 13; k++) begin
            apply(2'd2, 1'b0, 32'd0);
            if (k == 2) chk("pause reload", Dout, 32'd10);
            chk($sformatf("pause irq R+%0d", k), {31'h0, IRQ}, {31'h0, k == 13});
        end

        // PRESET rewritten mid-count: current count unaffected, next LOAD uses it
        do_reset();
        apply(2'd1, 1'b1, 32'd4);
        apply(2'd0, 1'b1, 32'hB);
        apply(2'd2, 1'b0, 32'd0);
        apply(2'd2, 1'b0, 32'd0);
        chk("midpreset count E+2", Dout, 32'd4);
        apply(2'd1, 1'b1, 32'd9);
        rd_chk("midpreset count E+3", 2'd2, 32'd3);
        rd_chk("midpreset preset",    2'd1, 32'd9);
        for (int k = 4; k <= 9; k++) begin
            apply(2'd2, 1'b0, 32'd0);
            chk($sformatf("midpreset irq E+%0d", k), {31'h0, IRQ}, {31'h0, k == 7});
        end
        chk("midpreset reload", Dout, 32'd9);

        // CTRL write on the INT cycle (mode 0): write wins, pending cleared, restart
        do_reset();
        apply(2'd1, 1'b1, 32'd1);
        apply(2'd0, 1'b1, 32'h9);
        for (int k = 1; k <= 4; k++) begin
            apply(2'd0, 1'b0, 32'd0);
            chk($sformatf("intwr irq E+%0d", k), {31'h0, IRQ}, {31'h0, k == 4});
        end
        apply(2'd0, 1'b1, 32'h9);
        chk("intwr ctrl", Dout, 32'h9);
        chk("intwr irq cleared", {31'h0, IRQ}, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            apply(2'd0, 1'b0, 32'd0);
            chk($sformatf("intwr irq X+%0d", k), {31'h0, IRQ}, {31'h0, k == 4});
        end

        // Reset while IRQ is asserted
        do_reset();
        chk("reset irq drop", {31'h0, IRQ}, 32'h0);
        rd_chk("reset ctrl again", 2'd0, 32'h0);

        // Read-only COUNT and unmapped offset
        apply(2'd1, 1'b1, 32'd5);
        apply(2'd2, 1'b1, 32'h55);
        chk("misc count write ignored", Dout, 32'h0);
        apply(2'd3, 1'b1, 32'h55);
        chk("misc reg3 reads 0", Dout, 32'h0);
        rd_chk("misc ctrl",   2'd0, 32'h0);
        rd_chk("misc preset", 2'd1, 32'd5);
        rd_chk("misc count",  2'd2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
